// File: rtl/mc_control_fsm.sv
// Registered multicycle MIPS control unit: Moore-decoded datapath controls, stall handshake,
// illegal-opcode pulse and retired-instruction counter. Define MC_CONTROL_BNE_EN to add BNE (S12).
module mc_control_fsm #(
    parameter int              OP_W     = 6,
    parameter int              CNT_W    = 16,
    parameter logic [OP_W-1:0] OP_RTYPE = 6'b000000,
    parameter logic [OP_W-1:0] OP_LW    = 6'b100011,
    parameter logic [OP_W-1:0] OP_SW    = 6'b101011,
    parameter logic [OP_W-1:0] OP_BEQ   = 6'b000100,
    parameter logic [OP_W-1:0] OP_J     = 6'b000010,
    parameter logic [OP_W-1:0] OP_ADDI  = 6'b001000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [OP_W-1:0]  Op,
    input  logic             mem_ready,
    output logic             PCWrite,
    output logic             PCWriteCond,
    output logic             IorD,
    output logic             MemRead,
    output logic             MemWrite,
    output logic             IRWrite,
    output logic             MemtoReg,
    output logic             RegWrite,
    output logic             RegDst,
    output logic             ALUSrcA,
    output logic [1:0]       PCSource,
    output logic [1:0]       ALUOp,
    output logic [1:0]       ALUSrcB,
    output logic             BranchNe,
    output logic [3:0]       state,
    output logic             illegal_op,
    output logic [CNT_W-1:0] instr_count
);

    typedef enum logic [3:0] {
        S0_FETCH     = 4'd0,
        S1_DECODE    = 4'd1,
        S2_MEMADR    = 4'd2,
        S3_MEMREAD   = 4'd3,
        S4_MEMWB     = 4'd4,
        S5_MEMWRITE  = 4'd5,
        S6_EXEC      = 4'd6,
        S7_RCOMPLETE = 4'd7,
        S8_BRANCH    = 4'd8,
        S9_JUMP      = 4'd9,
        S10_ADDI_EX  = 4'd10,
`ifdef MC_CONTROL_BNE_EN
        S11_ADDI_WB  = 4'd11,
        S12_BRANCHNE = 4'd12
`else
        S11_ADDI_WB  = 4'd11
`endif
    } state_t;

    localparam logic [OP_W-1:0] OP_BNE = 6'b000101;

    state_t           state_p0, state_d;
    logic             illegal_p0, illegal_d;
    logic [CNT_W-1:0] count_p0;
    logic             retire;

    logic pcwrite_c, pcwritecond_c, iord_c, memread_c, memwrite_c, irwrite_c;
    logic memtoreg_c, regwrite_c, regdst_c, alusrca_c;
    logic [1:0] pcsource_c, aluop_c, alusrcb_c;
`ifdef MC_CONTROL_BNE_EN
    logic branchne_c;
`endif

    // Stage p0: state, illegal pulse and retire counter
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_p0   <= S0_FETCH;
            illegal_p0 <= 1'b0;
            count_p0   <= '0;
        end else begin
            state_p0   <= state_d;
            illegal_p0 <= illegal_d;
            if (retire)
                count_p0 <= count_p0 + CNT_W'(1);
        end
    end

    always_comb begin
        state_d       = S0_FETCH;
        illegal_d     = 1'b0;
        retire        = 1'b0;
        pcwrite_c     = 1'b0;
        pcwritecond_c = 1'b0;
        iord_c        = 1'b0;
        memread_c     = 1'b0;
        memwrite_c    = 1'b0;
        irwrite_c     = 1'b0;
        memtoreg_c    = 1'b0;
        regwrite_c    = 1'b0;
        regdst_c      = 1'b0;
        alusrca_c     = 1'b0;
        pcsource_c    = 2'b00;
        aluop_c       = 2'b00;
        alusrcb_c     = 2'b00;
`ifdef MC_CONTROL_BNE_EN
        branchne_c    = 1'b0;
`endif
        case (state_p0)
            S0_FETCH: begin
                memread_c = 1'b1;
                alusrcb_c = 2'b01;
                irwrite_c = mem_ready;
                pcwrite_c = mem_ready;
                state_d   = mem_ready ? S1_DECODE : S0_FETCH;
            end
            S1_DECODE: begin
                alusrcb_c = 2'b11;
                if (Op == OP_LW || Op == OP_SW) state_d = S2_MEMADR;
                else if (Op == OP_RTYPE)        state_d = S6_EXEC;
                else if (Op == OP_BEQ)          state_d = S8_BRANCH;
                else if (Op == OP_J)            state_d = S9_JUMP;
                else if (Op == OP_ADDI)         state_d = S10_ADDI_EX;
`ifdef MC_CONTROL_BNE_EN
                else if (Op == OP_BNE)          state_d = S12_BRANCHNE;
`endif
                else                            illegal_d = 1'b1;
            end
            S2_MEMADR: begin
                alusrca_c = 1'b1;
                alusrcb_c = 2'b10;
                // An opcode that changed away from LW/SW here abandons the access
                if (Op == OP_LW)      state_d = S3_MEMREAD;
                else if (Op == OP_SW) state_d = S5_MEMWRITE;
            end
            S3_MEMREAD: begin
                memread_c = 1'b1;
                iord_c    = 1'b1;
                state_d   = mem_ready ? S4_MEMWB : S3_MEMREAD;
            end
            S4_MEMWB: begin
                regwrite_c = 1'b1;
                memtoreg_c = 1'b1;
                retire     = 1'b1;
            end
            S5_MEMWRITE: begin
                iord_c     = 1'b1;
                memwrite_c = mem_ready;
                retire     = mem_ready;
                state_d    = mem_ready ? S0_FETCH : S5_MEMWRITE;
            end
            S6_EXEC: begin
                alusrca_c = 1'b1;
                aluop_c   = 2'b10;
                state_d   = S7_RCOMPLETE;
            end
            S7_RCOMPLETE: begin
                regwrite_c = 1'b1;
                regdst_c   = 1'b1;
                retire     = 1'b1;
            end
            S8_BRANCH: begin
                alusrca_c     = 1'b1;
                aluop_c       = 2'b01;
                pcwritecond_c = 1'b1;
                pcsource_c    = 2'b01;
                retire        = 1'b1;
            end
            S9_JUMP: begin
                pcwrite_c  = 1'b1;
                pcsource_c = 2'b10;
                retire     = 1'b1;
            end
            S10_ADDI_EX: begin
                alusrca_c = 1'b1;
                alusrcb_c = 2'b10;
                state_d   = S11_ADDI_WB;
            end
            S11_ADDI_WB: begin
                regwrite_c = 1'b1;
                retire     = 1'b1;
            end
`ifdef MC_CONTROL_BNE_EN
            S12_BRANCHNE: begin
                alusrca_c     = 1'b1;
                aluop_c       = 2'b01;
                pcwritecond_c = 1'b1;
                pcsource_c    = 2'b01;
                branchne_c    = 1'b1;
                retire        = 1'b1;
            end
`endif
            default: state_d = S0_FETCH;
        endcase
    end

    // Reset masks the S0 decode so no enable is seen while reset is held
    assign PCWrite     = pcwrite_c     & ~reset;
    assign PCWriteCond = pcwritecond_c & ~reset;
    assign IorD        = iord_c        & ~reset;
    assign MemRead     = memread_c     & ~reset;
    assign MemWrite    = memwrite_c    & ~reset;
    assign IRWrite     = irwrite_c     & ~reset;
    assign MemtoReg    = memtoreg_c    & ~reset;
    assign RegWrite    = regwrite_c    & ~reset;
    assign RegDst      = regdst_c      & ~reset;
    assign ALUSrcA     = alusrca_c     & ~reset;
    assign PCSource    = pcsource_c    & {2{~reset}};
    assign ALUOp       = aluop_c       & {2{~reset}};
    assign ALUSrcB     = alusrcb_c     & {2{~reset}};
`ifdef MC_CONTROL_BNE_EN
    assign BranchNe    = branchne_c    & ~reset;
`else
    assign BranchNe    = 1'b0;
`endif
    assign state       = state_p0;
    assign illegal_op  = illegal_p0;
    assign instr_count = count_p0;

endmodule

// File: tb/tb_mc_control_fsm.sv
// Randomized bench for mc_control_fsm: an instruction-level model (per-opcode state paths,
// per-state control words) predicts state, controls, illegal pulse and retire count each cycle.
module tb_mc_control_fsm;

    localparam int CW = 4;
    localparam logic [5:0] OP_RTYPE = 6'b000000, OP_LW = 6'b100011, OP_SW = 6'b101011,
                           OP_BEQ = 6'b000100, OP_J = 6'b000010, OP_ADDI = 6'b001000,
                           OP_BNE = 6'b000101;
`ifdef MC_CONTROL_BNE_EN
    localparam bit BNE_EN = 1'b1;
`else
    localparam bit BNE_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic [5:0] Op = '0;
    logic mem_ready = 1'b0;
    logic PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg, RegWrite, RegDst, ALUSrcA;
    logic [1:0] PCSource, ALUOp, ALUSrcB;
    logic BranchNe, illegal_op;
    logic [3:0] state;
    logic [CW-1:0] instr_count;

    mc_control_fsm #(.CNT_W(CW)) dut (
        .clk(clk), .reset(reset), .Op(Op), .mem_ready(mem_ready),
        .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD), .MemRead(MemRead),
        .MemWrite(MemWrite), .IRWrite(IRWrite), .MemtoReg(MemtoReg), .RegWrite(RegWrite),
        .RegDst(RegDst), .ALUSrcA(ALUSrcA), .PCSource(PCSource), .ALUOp(ALUOp),
        .ALUSrcB(ALUSrcB), .BranchNe(BranchNe), .state(state), .illegal_op(illegal_op),
        .instr_count(instr_count)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, obs, exp);
        end
    endtask

    // Control word order: PCWrite PCWriteCond IorD MemRead MemWrite IRWrite MemtoReg RegWrite
    // RegDst ALUSrcA PCSource[2] ALUOp[2] ALUSrcB[2] BranchNe
    function automatic logic [16:0] pack(bit pcw, bit pcwc, bit iord, bit mrd, bit mwr, bit irw,
                                         bit m2r, bit rw, bit rd, bit asa, logic [1:0] pcs,
                                         logic [1:0] aop, logic [1:0] asb, bit bne);
        return {pcw, pcwc, iord, mrd, mwr, irw, m2r, rw, rd, asa, pcs, aop, asb, bne};
    endfunction

    function automatic logic [16:0] exp_ctrl(int s, bit mr);
        case (s)
            0:  return pack(mr,0,0,1,0,mr,0,0,0,0, 2'b00,2'b00,2'b01,0);
            1:  return pack(0,0,0,0,0,0,0,0,0,0, 2'b00,2'b00,2'b11,0);
            2:  return pack(0,0,0,0,0,0,0,0,0,1, 2'b00,2'b00,2'b10,0);
            3:  return pack(0,0,1,1,0,0,0,0,0,0, 2'b00,2'b00,2'b00,0);
            4:  return pack(0,0,0,0,0,0,1,1,0,0, 2'b00,2'b00,2'b00,0);
            5:  return pack(0,0,1,0,mr,0,0,0,0,0, 2'b00,2'b00,2'b00,0);
            6:  return pack(0,0,0,0,0,0,0,0,0,1, 2'b00,2'b10,2'b00,0);
            7:  return pack(0,0,0,0,0,0,0,1,1,0, 2'b00,2'b00,2'b00,0);
            8:  return pack(0,1,0,0,0,0,0,0,0,1, 2'b01,2'b01,2'b00,0);
            9:  return pack(1,0,0,0,0,0,0,0,0,0, 2'b10,2'b00,2'b00,0);
            10: return pack(0,0,0,0,0,0,0,0,0,1, 2'b00,2'b00,2'b10,0);
            11: return pack(0,0,0,0,0,0,0,1,0,0, 2'b00,2'b00,2'b00,0);
            12: return pack(0,1,0,0,0,0,0,0,0,1, 2'b01,2'b01,2'b00,1);
            default: return '0;
        endcase
    endfunction

    wire [16:0] ctrl = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg,
                        RegWrite, RegDst, ALUSrcA, PCSource, ALUOp, ALUSrcB, BranchNe};

    // Instruction-level model
    int        path[$];
    int        idx;
    logic [5:0] cur_op;
    bit        cur_ill;
    bit        need_new;
    bit        m_illegal;
    int        m_count;
    int        n_done;
    logic [5:0] opq[$];
    bit        mrq[$];
    bit        mr_always;

    task automatic new_instr();
        logic [5:0] legal [7];
        legal = '{OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI, OP_BNE};
        if (opq.size() > 0) cur_op = opq.pop_front();
        else if ($urandom_range(0, 7) == 0) cur_op = 6'($urandom);
        else cur_op = legal[$urandom_range(0, 6)];
        cur_ill = 1'b0;
        case (cur_op)
            OP_LW:    path = '{0, 1, 2, 3, 4};
            OP_SW:    path = '{0, 1, 2, 5};
            OP_RTYPE: path = '{0, 1, 6, 7};
            OP_BEQ:   path = '{0, 1, 8};
            OP_J:     path = '{0, 1, 9};
            OP_ADDI:  path = '{0, 1, 10, 11};
            OP_BNE: begin
                if (BNE_EN) path = '{0, 1, 12};
                else begin path = '{0, 1}; cur_ill = 1'b1; end
            end
            default: begin path = '{0, 1}; cur_ill = 1'b1; end
        endcase
        idx = 0;
    endtask

    task automatic step();
        int s;
        @(negedge clk);
        if (need_new) begin new_instr(); need_new = 1'b0; end
        s = path[idx];
        Op = (s == 1 || s == 2) ? cur_op : 6'($urandom);
        if (mrq.size() > 0) mem_ready = mrq.pop_front();
        else mem_ready = mr_always ? 1'b1 : ($urandom_range(0, 9) < 7);
        #1;
        chk("state", 32'(state), 32'(s));
        chk("ctrl", 32'(ctrl), 32'(exp_ctrl(s, mem_ready)));
        chk("illegal_op", 32'(illegal_op), 32'(m_illegal));
        chk("instr_count", 32'(instr_count), 32'(m_count));
        m_illegal = 1'b0;
        if (!(s == 0 || s == 3 || s == 5) || mem_ready) begin
            idx++;
            if (idx == path.size()) begin
                if (!cur_ill) m_count = (m_count + 1) % (1 << CW);
                m_illegal = cur_ill;
                n_done++;
                need_new = 1'b1;
            end
        end
    endtask

    task automatic run_instrs(int k);
        int target = n_done + k;
        int guard = 0;
        while (n_done < target && guard < 5000) begin
            step();
            guard++;
        end
        if (n_done < target) chk("instr_timeout", 32'(n_done), 32'(target));
    endtask

    task automatic check_reset_outputs(string tag);
        chk({tag, "_state"}, 32'(state), 32'd0);
        chk({tag, "_ctrl"}, 32'(ctrl), 32'd0);
        chk({tag, "_illegal"}, 32'(illegal_op), 32'd0);
        chk({tag, "_count"}, 32'(instr_count), 32'd0);
    endtask

    task automatic model_reset();
        m_count = 0; m_illegal = 1'b0; need_new = 1'b1; idx = 0;
    endtask

    initial begin
        n_done = 0; mr_always = 1'b1; model_reset();
        mem_ready = 1'b1;
        repeat (2) @(negedge clk);
        #1 check_reset_outputs("por");
        @(posedge clk); #1 reset = 1'b0;

        // LW, memory always ready
        opq.push_back(OP_LW);
        run_instrs(1);
        // SW with three stalled cycles in S5
        opq.push_back(OP_SW);
        mrq = '{1, 1, 1, 0, 0, 0, 1};
        run_instrs(1);
        // Fetch stall of two cycles
        opq.push_back(OP_RTYPE);
        mrq = '{0, 0, 1};
        run_instrs(1);
        // Illegal opcode, then ADDI / BEQ / J
        opq.push_back(6'b111111);
        opq.push_back(OP_ADDI);
        opq.push_back(OP_BEQ);
        opq.push_back(OP_J);
        run_instrs(4);
        step();

        // Reset while in S3 of a load
        opq.push_back(OP_LW);
        while (!(need_new == 1'b0 && path[idx] == 3)) step();
        @(negedge clk); #2 reset = 1'b1;
        #1 check_reset_outputs("mid_reset");
        @(negedge clk); #1 check_reset_outputs("held_reset");
        model_reset();
        @(posedge clk); #1 reset = 1'b0;
        opq.push_back(OP_BNE);
        run_instrs(2);

        // Randomized instruction stream, random memory stalls, counter wraps
        mr_always = 1'b0;
        run_instrs(300);
        step();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
